// File: rtl/icache_refill_ctrl_pkg.sv
// ============================================================================
// icache_refill_ctrl_pkg : shared widths and refill FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package icache_refill_ctrl_pkg;

   localparam int ADDR_WIDTH         = 32;
   localparam int ICACHE_BLOCK_WIDTH = 64;
   localparam int DRAM_BEAT_WIDTH    = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_COLLECT = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_FILL    = 3'd4
   } refill_state_e;

   // Beat counter width; a single-beat line still needs one bit.
   function automatic int cnt_width(input int nbeats);
      return (nbeats > 1) ? $clog2(nbeats) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/icache_refill_ctrl_beat_assembler.sv
// ============================================================================
// refill_beat_assembler : counts DRAM beats and packs them into one line
// Rev 1.0
// ============================================================================
`default_nettype none

module refill_beat_assembler #(
   parameter int BLOCK_WIDTH = icache_refill_ctrl_pkg::ICACHE_BLOCK_WIDTH,
   parameter int BEAT_WIDTH  = icache_refill_ctrl_pkg::DRAM_BEAT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_i,
   input  logic                   beat_valid_i,
   input  logic [BEAT_WIDTH-1:0]  beat_data_i,
   output logic                   last_beat_o,
   output logic [BLOCK_WIDTH-1:0] line_data_o
);
   import icache_refill_ctrl_pkg::*;

   localparam int NBEATS = BLOCK_WIDTH / BEAT_WIDTH;
   localparam int CNT_W  = cnt_width(NBEATS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

   logic [CNT_W-1:0]       beat_cnt_q;
   logic [BLOCK_WIDTH-1:0] line_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q <= '0;
      end else if (clear_i) begin
         beat_cnt_q <= '0;
      end else if (beat_valid_i) begin
         beat_cnt_q <= (beat_cnt_q == LAST_CNT) ? '0 : beat_cnt_q + 1'b1;
      end
   end

   generate
      if (NBEATS > 1) begin : g_multi_beat
         always_ff @(posedge clk) begin
            if (rst) begin
               line_q <= '0;
            end else if (beat_valid_i && !clear_i) begin
               line_q[beat_cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data_i;
            end
         end
      end else begin : g_single_beat
         always_ff @(posedge clk) begin
            if (rst) begin
               line_q <= '0;
            end else if (beat_valid_i && !clear_i) begin
               line_q <= beat_data_i;
            end
         end
      end
   endgenerate

   assign last_beat_o = (beat_cnt_q == LAST_CNT);
   assign line_data_o = line_q;

endmodule

`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
// ============================================================================
// icache_refill_ctrl : icache miss refill FSM with branch-recovery flush
// Rev 1.0
// ============================================================================
`default_nettype none

module icache_refill_ctrl #(
   parameter int ADDR_WIDTH  = icache_refill_ctrl_pkg::ADDR_WIDTH,
   parameter int BLOCK_WIDTH = icache_refill_ctrl_pkg::ICACHE_BLOCK_WIDTH,
   parameter int BEAT_WIDTH  = icache_refill_ctrl_pkg::DRAM_BEAT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   miss_valid_i,
   input  logic [ADDR_WIDTH-1:0]  miss_addr_i,
   input  logic                   flush_i,
   output logic                   busy_o,
   output logic                   dram_req_valid_o,
   input  logic                   dram_req_ready_i,
   output logic [ADDR_WIDTH-1:0]  dram_req_addr_o,
   input  logic                   dram_rsp_valid_i,
   input  logic [BEAT_WIDTH-1:0]  dram_rsp_data_i,
   output logic                   fill_valid_o,
   output logic [ADDR_WIDTH-1:0]  fill_addr_o,
   output logic [BLOCK_WIDTH-1:0] fill_data_o
);
   import icache_refill_ctrl_pkg::*;

   localparam int OFF = $clog2(BLOCK_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

   refill_state_e         state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] line_addr;
   logic                  accept_miss;
   logic                  beat_valid;
   logic                  last_beat;

   assign line_addr   = miss_addr_i & LINE_MASK;
   assign accept_miss = (state_q == ST_IDLE) && miss_valid_i && !flush_i;
   // Beats outside COLLECT/DRAIN are protocol violations and never reach the counter.
   assign beat_valid  = dram_rsp_valid_i && ((state_q == ST_COLLECT) || (state_q == ST_DRAIN));

   refill_beat_assembler #(
      .BLOCK_WIDTH (BLOCK_WIDTH),
      .BEAT_WIDTH  (BEAT_WIDTH)
   ) u_beat_asm (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (accept_miss),
      .beat_valid_i (beat_valid),
      .beat_data_i  (dram_rsp_data_i),
      .last_beat_o  (last_beat),
      .line_data_o  (fill_data_o)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_miss) begin
                  addr_q  <= line_addr;
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (dram_req_ready_i) begin
                  state_q <= flush_i ? ST_DRAIN : ST_COLLECT;
               end else if (flush_i) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_COLLECT: begin
               // A flush still lets the in-flight beats arrive; only the fill is cancelled.
               if (beat_valid && last_beat) begin
                  state_q <= flush_i ? ST_IDLE : ST_FILL;
               end else if (flush_i) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (beat_valid && last_beat) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_FILL: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o           = (state_q != ST_IDLE);
   assign dram_req_valid_o = (state_q == ST_REQ);
   assign dram_req_addr_o  = addr_q;
   assign fill_valid_o     = (state_q == ST_FILL);
   assign fill_addr_o      = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
// ============================================================================
// tb_icache_refill_ctrl : directed and random checks against a transaction model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_icache_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_valid = 1'b0;
   logic [31:0] miss_addr = '0;
   logic        flush = 1'b0;
   logic        dram_req_ready = 1'b0;
   logic        dram_rsp_valid = 1'b0;
   logic [31:0] dram_rsp_data = '0;
   logic        busy, dram_req_valid, fill_valid;
   logic [31:0] dram_req_addr, fill_addr;
   logic [63:0] fill_data;

   always #5 clk = ~clk;

   icache_refill_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .miss_valid_i     (miss_valid),
      .miss_addr_i      (miss_addr),
      .flush_i          (flush),
      .busy_o           (busy),
      .dram_req_valid_o (dram_req_valid),
      .dram_req_ready_i (dram_req_ready),
      .dram_req_addr_o  (dram_req_addr),
      .dram_rsp_valid_i (dram_rsp_valid),
      .dram_rsp_data_i  (dram_rsp_data),
      .fill_valid_o     (fill_valid),
      .fill_addr_o      (fill_addr),
      .fill_data_o      (fill_data)
   );

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;
   int fill_cnt = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Transaction model: a pending request, a count of beats still owed by DRAM,
   // whether the line is still wanted, and a one-cycle fill.
   bit          m_req = 0, m_keep = 0, m_fill = 0;
   int          m_left = 0, m_got = 0;
   logic [31:0] m_addr = '0;
   logic [63:0] m_line = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_req = 0; m_keep = 0; m_fill = 0; m_left = 0; m_got = 0;
         m_addr = '0; m_line = '0;
      end else if (m_fill) begin
         m_fill = 0;
      end else if (m_req) begin
         if (dram_req_ready) begin
            m_req = 0; m_left = 2; m_got = 0; m_keep = !flush;
         end else if (flush) begin
            m_req = 0;
         end
      end else if (m_left > 0) begin
         if (dram_rsp_valid) begin
            m_line[m_got*32 +: 32] = dram_rsp_data;
            m_got++;
            m_left--;
            if (m_left == 0) m_fill = m_keep && !flush;
         end
         if (flush) m_keep = 0;
      end else if (miss_valid && !flush) begin
         m_req  = 1;
         m_addr = miss_addr & 32'hFFFF_FFF8;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, (m_req || m_left > 0 || m_fill));
         chk("req_valid", dram_req_valid, m_req);
         if (m_req) chk("req_addr", dram_req_addr, m_addr);
         chk("fill_valid", fill_valid, m_fill);
         if (m_fill) begin
            chk("fill_addr", fill_addr, m_addr);
            chk("fill_data", fill_data, m_line);
         end
         if (fill_valid) fill_cnt++;
      end
   end

   // Drives the inputs for the next rising edge; on return, DUT outputs reflect the previous call.
   task automatic cyc(input bit mv, input logic [31:0] ma, input bit fl, input bit rdy,
                      input bit rv, input logic [31:0] rd);
      @(negedge clk);
      #1;
      miss_valid = mv; miss_addr = ma; flush = fl;
      dram_req_ready = rdy; dram_rsp_valid = rv; dram_rsp_data = rd;
      if (dram_req_valid && rdy) hs_cnt++;
   endtask

   int hs0, f0;

   initial begin
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_req_valid", dram_req_valid, 0);
      chk("rst_fill_valid", fill_valid, 0);
      rst = 1'b0;

      // Basic two-beat refill
      f0 = fill_cnt;
      cyc(1, 32'h0000_1234, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      chk("t2_req_valid", dram_req_valid, 1);
      chk("t2_req_addr", dram_req_addr, 32'h0000_1230);
      cyc(0, 0, 0, 0, 1, 32'hAAAA_0001);
      cyc(0, 0, 0, 0, 1, 32'hBBBB_0002);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t2_fill_valid", fill_valid, 1);
      chk("t2_fill_addr", fill_addr, 32'h0000_1230);
      chk("t2_fill_data", fill_data, 64'hBBBB_0002_AAAA_0001);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t2_fill_pulse", fill_valid, 0);
      chk("t2_fill_count", 64'(fill_cnt - f0), 1);

      // Reset held two cycles in the middle of COLLECT
      cyc(1, 32'h0000_4444, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h1111_1111);
      rst = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      chk("t1_busy", busy, 0);
      chk("t1_req_valid", dram_req_valid, 0);
      chk("t1_fill_valid", fill_valid, 0);
      cyc(1, 32'h0000_567C, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h1357_9BDF);
      cyc(0, 0, 0, 0, 1, 32'h0246_8ACE);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t1_fill_addr", fill_addr, 32'h0000_5678);
      chk("t1_fill_data", fill_data, 64'h0246_8ACE_1357_9BDF);

      // Request backpressure
      hs0 = hs_cnt;
      cyc(1, 32'h8000_0014, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         chk("t3_req_valid", dram_req_valid, 1);
         chk("t3_req_addr", dram_req_addr, 32'h8000_0010);
      end
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'hCAFE_0000);
      cyc(0, 0, 0, 0, 1, 32'hCAFE_0001);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t3_fill_data", fill_data, 64'hCAFE_0001_CAFE_0000);
      chk("t3_handshakes", 64'(hs_cnt - hs0), 1);

      // Flush in REQ without ready, then flush together with ready
      hs0 = hs_cnt;
      cyc(1, 32'h0000_0100, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t4a_busy", busy, 0);
      chk("t4a_handshakes", 64'(hs_cnt - hs0), 0);
      f0 = fill_cnt;
      cyc(1, 32'h0000_0200, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'hDEAD_0000);
      chk("t4b_drain_busy0", busy, 1);
      cyc(0, 0, 0, 0, 1, 32'hDEAD_0001);
      chk("t4b_drain_busy1", busy, 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t4b_idle", busy, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t4b_fills", 64'(fill_cnt - f0), 0);

      // Flush after beat 0, late beat 1, then a fresh miss
      f0 = fill_cnt;
      cyc(1, 32'h0000_0300, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h5555_0000);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h5555_0001);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t5_idle", busy, 0);
      chk("t5_no_fill", 64'(fill_cnt - f0), 0);
      cyc(1, 32'h0000_2000, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h7777_0000);
      cyc(0, 0, 0, 0, 1, 32'h7777_0001);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t5_fill_addr", fill_addr, 32'h0000_2000);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t5_one_fill", 64'(fill_cnt - f0), 1);

      // Spurious beats in IDLE, then miss held high for a whole refill
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t6_idle_busy", busy, 0);
      hs0 = hs_cnt;
      f0  = fill_cnt;
      cyc(1, 32'h0000_3004, 0, 1, 0, 0);
      cyc(1, 32'h0000_3004, 0, 1, 0, 0);
      cyc(1, 32'h0000_3004, 0, 1, 1, 32'h1234_5678);
      cyc(1, 32'h0000_3004, 0, 1, 1, 32'h9ABC_DEF0);
      cyc(1, 32'h0000_3004, 0, 1, 0, 0);
      chk("t6_fill_data", fill_data, 64'h9ABC_DEF0_1234_5678);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t6_handshakes", 64'(hs_cnt - hs0), 1);
      chk("t6_fills", 64'(fill_cnt - f0), 1);

      // Randomised traffic, model-checked every cycle
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(299) == 0);
         cyc(($urandom_range(3) == 0), $urandom, ($urandom_range(9) == 0),
             $urandom_range(1), $urandom_range(1), $urandom);
      end
      rst = 1'b0;
      repeat (4) cyc(0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
